// File: rtl/bip_pkg.sv
// Shared opcode, mux-select, ALU-op and FSM-state encodings for the BIP control unit.
package bip_pkg;

  localparam logic [4:0] OPC_HLT  = 5'b00000;
  localparam logic [4:0] OPC_STO  = 5'b00001;
  localparam logic [4:0] OPC_LD   = 5'b00010;
  localparam logic [4:0] OPC_LDI  = 5'b00011;
  localparam logic [4:0] OPC_ADD  = 5'b00100;
  localparam logic [4:0] OPC_ADDI = 5'b00101;
  localparam logic [4:0] OPC_SUB  = 5'b00110;
  localparam logic [4:0] OPC_SUBI = 5'b00111;

  localparam logic [1:0] SEL_A_RAM = 2'd0;
  localparam logic [1:0] SEL_A_IMM = 2'd1;
  localparam logic [1:0] SEL_A_ALU = 2'd2;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

endpackage

// File: rtl/bip_decoder.sv
// Combinational opcode -> control-word table; every output is forced low unless run_i is set.
module bip_decoder
  import bip_pkg::*;
(
  input  logic       run_i,
  input  logic [4:0] opcode_i,
  output logic [1:0] selA_o,
  output logic       selB_o,
  output logic       op_o,
  output logic       wrAcc_o,
  output logic       wrRam_o,
  output logic       rdRam_o
);

  // Undefined opcodes fall through to the all-zero default and behave as NOP.
  always_comb begin
    selA_o  = SEL_A_RAM;
    selB_o  = 1'b0;
    op_o    = OP_ADD;
    wrAcc_o = 1'b0;
    wrRam_o = 1'b0;
    rdRam_o = 1'b0;
    if (run_i) begin
      case (opcode_i)
        OPC_STO: wrRam_o = 1'b1;
        OPC_LD: begin
          selA_o  = SEL_A_RAM;
          wrAcc_o = 1'b1;
          rdRam_o = 1'b1;
        end
        OPC_LDI: begin
          selA_o  = SEL_A_IMM;
          wrAcc_o = 1'b1;
        end
        OPC_ADD: begin
          selA_o  = SEL_A_ALU;
          wrAcc_o = 1'b1;
          rdRam_o = 1'b1;
        end
        OPC_ADDI: begin
          selA_o  = SEL_A_ALU;
          selB_o  = 1'b1;
          wrAcc_o = 1'b1;
        end
        OPC_SUB: begin
          selA_o  = SEL_A_ALU;
          op_o    = OP_SUB;
          wrAcc_o = 1'b1;
          rdRam_o = 1'b1;
        end
        OPC_SUBI: begin
          selA_o  = SEL_A_ALU;
          selB_o  = 1'b1;
          op_o    = OP_SUB;
          wrAcc_o = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/bip_control_unit.sv
// BIP control unit: IDLE/RUN/HALT sequencing, program counter and instruction decode.
// Defining BIP_CYCLE_COUNT_EN adds a saturating CycleCount of edges spent in RUN.
module bip_control_unit
  import bip_pkg::*;
#(
  parameter int PC_W  = 11,
  parameter int OPC_W = 5,
  parameter int CNT_W = 32
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            Start,
  input  logic [15:0]     Instr,
  output logic [PC_W-1:0] PcAddr,
  output logic [1:0]      SelA,
  output logic            SelB,
  output logic            Op,
  output logic            WrAcc,
  output logic            WrRam,
  output logic            RdRam,
  output logic            Busy,
`ifdef BIP_CYCLE_COUNT_EN
  output logic            Halted,
  output logic [CNT_W-1:0] CycleCount
`else
  output logic            Halted
`endif
);

  state_e            state_q;
  logic [PC_W-1:0]   pc_q;
  logic              busy_q;
  logic              halted_q;
  logic [OPC_W-1:0]  opcode;
  logic              instrUnused;

  assign opcode      = Instr[15 -: OPC_W];
  assign instrUnused = ^Instr[15-OPC_W:0];

  // Busy/Halted are updated alongside the state so they never depend on Start combinationally.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (Start) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (opcode == OPC_HLT) begin
            state_q  <= ST_HALT;
            busy_q   <= 1'b0;
            halted_q <= 1'b1;
          end else begin
            pc_q <= pc_q + 1'b1;
          end
        end
        ST_HALT: ;
        default: begin
          state_q  <= ST_IDLE;
          busy_q   <= 1'b0;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  bip_decoder uDecoder (
    .run_i    (state_q == ST_RUN),
    .opcode_i (opcode),
    .selA_o   (SelA),
    .selB_o   (SelB),
    .op_o     (Op),
    .wrAcc_o  (WrAcc),
    .wrRam_o  (WrRam),
    .rdRam_o  (RdRam)
  );

  assign PcAddr = pc_q;
  assign Busy   = busy_q;
  assign Halted = halted_q;

`ifdef BIP_CYCLE_COUNT_EN
  logic [CNT_W-1:0] cycleCnt_q;
  logic [CNT_W-1:0] cycleCnt_d;

  // The HLT-decode edge is still a RUN edge, so it is counted; HALT and IDLE hold the value.
  always_comb begin
    cycleCnt_d = cycleCnt_q;
    if (state_q == ST_RUN && cycleCnt_q != {CNT_W{1'b1}}) begin
      cycleCnt_d = cycleCnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      cycleCnt_q <= '0;
    end else begin
      cycleCnt_q <= cycleCnt_d;
    end
  end

  assign CycleCount = cycleCnt_q;
`endif

endmodule
